// File: rtl/rv32_fetch_pkg.sv
// Types and helpers shared by the buffered fetch stage and its prefetch FIFO.
//   fetch_entry_t : one buffered instruction together with its pc.
//   align_pc      : forces a byte address onto a 32-bit word boundary.
package rv32_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/rv32_opcodes_pkg.sv
// Shared RV32 opcode constants used across the pipeline.
//   RV32_INSTR_NOP : canonical NOP (addi x0, x0, 0), used to fill empty slots.
package rv32_opcodes;

    localparam logic [31:0] RV32_INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t, head visible combinationally.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push         : write push_data at the tail
//   pop          : drop the head entry (pop_data is the current head)
//   clear        : empty the FIFO; takes priority over push and pop
//   full, empty  : occupancy flags
//   count        : number of valid entries (0..DEPTH)
module rv32_fetch_fifo
    import rv32_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  fetch_entry_t           push_data,
    output fetch_entry_t           pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/rv32_fetch_buffered.sv
// Buffered RV32 fetch stage: issues word fetches over a valid/ready bus with
// several requests in flight, buffers responses in a prefetch FIFO and feeds
// decode through a registered output slot.
// Handshake: a request transfers in a cycle where imem_req_valid and
// imem_req_ready are both high; imem_req_valid never waits on ready.
// Responses arrive in order, one per imem_resp_valid strobe, no backpressure.
// Ports:
//   clk, reset_n                     : clock, asynchronous active-low reset
//   stall                            : decode stall, holds the output slot
//   flush                            : replaces the output slot with a NOP
//   branch_taken_in, branch_pc_in    : redirect from mem (target word-aligned)
//   imem_req_valid/ready/addr        : request channel
//   imem_resp_valid/data             : response channel
//   valid_out, pc_out, instr_out     : registered output slot to decode
module rv32_fetch_buffered
    import rv32_opcodes::*;
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_pc_in,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Held low until the first edge after reset release so that the bus
    // sees no request while reset is (or has just been) asserted.
    logic          run_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          valid_q, valid_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;

    logic [CW-1:0] fifo_count;
    logic [CW-1:0] room;
    logic          fifo_full, fifo_empty;
    logic          fifo_push, fifo_pop;
    fetch_entry_t  fifo_head, resp_entry;
    logic [31:0]   target_pc;
    logic          req_hs, resp_keep, out_load, bypass;

    assign target_pc = align_pc(branch_pc_in);

    // Credit: every request not yet answered (and not being discarded) owns
    // a FIFO slot, so a push can never find the FIFO full.
    assign room           = CW'(FIFO_DEPTH) - fifo_count - (inflight_q - drop_q);
    assign imem_req_valid = run_q && (room != '0) && !branch_taken_in;
    assign imem_req_addr  = fetch_pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;

    // A response arriving with a redirect belongs to the old path.
    assign resp_keep  = imem_resp_valid && (drop_q == '0) && !branch_taken_in;
    assign out_load   = !stall && !flush && !branch_taken_in;
    assign fifo_pop   = out_load && !fifo_empty;
    // With nothing buffered, a kept response goes straight to the output
    // slot, giving one cycle from response to valid_out.
    assign bypass     = out_load && fifo_empty && resp_keep;
    // full here would mean the credit count is wrong; refuse the write
    // rather than corrupt the head.
    assign fifo_push  = resp_keep && !bypass && !fifo_full;
    assign resp_entry = '{pc: resp_pc_q, instr: imem_resp_data};

    rv32_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (branch_taken_in),
        .push_data (resp_entry),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q + CW'(req_hs) - CW'(imem_resp_valid);
        drop_d     = drop_q;

        if (branch_taken_in) begin
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            // Everything still outstanding after this cycle is stale.
            drop_d     = inflight_q - CW'(imem_resp_valid);
        end else begin
            if (req_hs) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_keep) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (imem_resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (!stall) begin
            if (fifo_pop) begin
                valid_d = 1'b1;
                pc_d    = fifo_head.pc;
                instr_d = fifo_head.instr;
            end else if (bypass) begin
                valid_d = 1'b1;
                pc_d    = resp_pc_q;
                instr_d = imem_resp_data;
            end else begin
                valid_d = 1'b0;
                instr_d = RV32_INSTR_NOP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            instr_q    <= RV32_INSTR_NOP;
        end else begin
            run_q      <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
        end
    end

    assign valid_out = valid_q;
    assign pc_out    = pc_q;
    assign instr_out = instr_q;

endmodule

// File: tb/tb_rv32_fetch_buffered.sv
module tb_rv32_fetch_buffered;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] XOR_KEY = 32'hA5A5_A5A5;
  localparam int          NVEC    = 19;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken_in = 1'b0;
  logic [31:0] branch_pc_in = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;

  always #5 clk = ~clk;

  rv32_fetch_buffered #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall           (stall),
    .flush           (flush),
    .branch_taken_in (branch_taken_in),
    .branch_pc_in    (branch_pc_in),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .valid_out       (valid_out),
    .pc_out          (pc_out),
    .instr_out       (instr_out)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- instruction bus model ----------------
  // In-order memory: a request accepted in cycle c answers in cycle
  // c + bus_lat with data = addr ^ XOR_KEY.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t pend_q[$];
  int    cyc = 0;
  int    bus_lat = 1;
  int    hs_count = 0;

  always begin
    @(negedge clk);
    #2;
    if (reset_n && imem_req_valid && imem_req_ready) begin
      pend_q.push_back('{addr: imem_req_addr, due: cyc + bus_lat});
      hs_count++;
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (!reset_n) begin
      pend_q.delete();
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = pend_q[0].addr ^ XOR_KEY;
      void'(pend_q.pop_front());
    end
  end

  // FIFO must never be written when full or read when empty.
  always begin
    @(negedge clk);
    #4;
    if (reset_n) begin
      checks++;
      if ((dut.u_fifo.push && dut.u_fifo.full) || (dut.u_fifo.pop && dut.u_fifo.empty)) begin
        failures++;
        $display("FAIL fifo_guard: push=%0b full=%0b pop=%0b empty=%0b required no overflow/underflow",
                 dut.u_fifo.push, dut.u_fifo.full, dut.u_fifo.pop, dut.u_fifo.empty);
      end
    end
  end

  // ---------------- check helpers / scoreboard ----------------
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic        s_req_valid;
  logic [31:0] s_req_addr;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs at negedge, sample the request channel
  // mid-cycle, then sample registered outputs just after the rising edge.
  task automatic step(input logic st, input logic fl, input logic rd,
                      input logic br, input logic [31:0] bpc);
    @(negedge clk);
    stall           = st;
    flush           = fl;
    imem_req_ready  = rd;
    branch_taken_in = br;
    branch_pc_in    = bpc;
    #3;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    @(posedge clk);
    #1;
    if (mon_en && valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra: got pc %h expected no valid output", pc_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check32("sb_pc", pc_out, e);
        check32("sb_instr", instr_out, e ^ XOR_KEY);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n         = 1'b0;
    stall           = 1'b0;
    flush           = 1'b0;
    branch_taken_in = 1'b0;
    branch_pc_in    = '0;
    imem_req_ready  = 1'b1;
    mon_en          = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        stall;
    logic        flush;
    logic        ready;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[NVEC];

  task automatic set_vec(input int i, input logic st, input logic fl, input logic rd,
                         input logic rv, input logic [31:0] ra,
                         input logic v, input logic [31:0] pc, input logic [31:0] ins);
    vecs[i] = '{stall: st, flush: fl, ready: rd, exp_req_valid: rv, exp_req_addr: ra,
                exp_valid: v, exp_pc: pc, exp_instr: ins};
  endtask

  initial begin
    // straight-line, flush, short stall, ready low (bus latency 1)
    //          st fl rd  rv  addr          v   pc            instr
    set_vec( 0, 0, 0, 1,  1, 32'h00,       0, 32'h00, 32'h0000_0013);
    set_vec( 1, 0, 0, 1,  1, 32'h04,       1, 32'h00, 32'hA5A5_A5A5);
    set_vec( 2, 0, 0, 1,  1, 32'h08,       1, 32'h04, 32'hA5A5_A5A1);
    set_vec( 3, 0, 0, 1,  1, 32'h0C,       1, 32'h08, 32'hA5A5_A5AD);
    set_vec( 4, 0, 0, 1,  1, 32'h10,       1, 32'h0C, 32'hA5A5_A5A9);
    set_vec( 5, 0, 1, 1,  1, 32'h14,       0, 32'h0C, 32'h0000_0013);
    set_vec( 6, 0, 0, 1,  1, 32'h18,       1, 32'h10, 32'hA5A5_A5B5);
    set_vec( 7, 0, 0, 1,  1, 32'h1C,       1, 32'h14, 32'hA5A5_A5B1);
    set_vec( 8, 1, 0, 1,  1, 32'h20,       1, 32'h14, 32'hA5A5_A5B1);
    set_vec( 9, 1, 0, 1,  1, 32'h24,       1, 32'h14, 32'hA5A5_A5B1);
    set_vec(10, 1, 0, 1,  0, 32'h28,       1, 32'h14, 32'hA5A5_A5B1);
    set_vec(11, 1, 0, 1,  0, 32'h28,       1, 32'h14, 32'hA5A5_A5B1);
    set_vec(12, 0, 0, 1,  0, 32'h28,       1, 32'h18, 32'hA5A5_A5BD);
    set_vec(13, 0, 0, 1,  1, 32'h28,       1, 32'h1C, 32'hA5A5_A5B9);
    set_vec(14, 0, 0, 1,  1, 32'h2C,       1, 32'h20, 32'hA5A5_A585);
    set_vec(15, 0, 0, 1,  1, 32'h30,       1, 32'h24, 32'hA5A5_A581);
    set_vec(16, 0, 0, 0,  1, 32'h34,       1, 32'h28, 32'hA5A5_A58D);
    set_vec(17, 0, 0, 1,  1, 32'h34,       1, 32'h2C, 32'hA5A5_A589);
    set_vec(18, 0, 0, 1,  1, 32'h38,       1, 32'h30, 32'hA5A5_A595);

    // reset state
    bus_lat = 1;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_req_valid", imem_req_valid, 1'b0);
    check1("rst_valid_out", valid_out, 1'b0);
    check32("rst_pc_out", pc_out, 32'h0);
    check32("rst_instr_out", instr_out, NOP);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].stall, vecs[i].flush, vecs[i].ready, 1'b0, 32'h0);
      check1($sformatf("v%0d_req_valid", i), s_req_valid, vecs[i].exp_req_valid);
      check32($sformatf("v%0d_req_addr", i), s_req_addr, vecs[i].exp_req_addr);
      check1($sformatf("v%0d_valid_out", i), valid_out, vecs[i].exp_valid);
      check32($sformatf("v%0d_pc_out", i), pc_out, vecs[i].exp_pc);
      check32($sformatf("v%0d_instr_out", i), instr_out, vecs[i].exp_instr);
    end

    // redirect with two requests in flight, unaligned target
    bus_lat = 3;
    do_reset();
    mon_en = 1'b1;
    exp_q = '{32'h100, 32'h104, 32'h108};
    step(0, 0, 1, 0, 32'h0);
    check32("a_req0_addr", s_req_addr, 32'h0);
    step(0, 0, 1, 0, 32'h0);
    check32("a_req1_addr", s_req_addr, 32'h4);
    step(0, 0, 1, 1, 32'h0000_0103);
    check1("a_br_req_valid", s_req_valid, 1'b0);
    step(0, 0, 1, 0, 32'h0);
    check1("a_post_req_valid", s_req_valid, 1'b1);
    check32("a_post_req_addr", s_req_addr, 32'h100);
    repeat (5) step(0, 0, 1, 0, 32'h0);
    check32("a_drained", 32'(exp_q.size()), 32'h0);

    // redirect in the same cycle as a response
    bus_lat = 3;
    do_reset();
    mon_en = 1'b1;
    exp_q = '{32'h200, 32'h204, 32'h208};
    repeat (3) step(0, 0, 1, 0, 32'h0);
    check32("b_req2_addr", s_req_addr, 32'h8);
    step(0, 0, 1, 1, 32'h0000_0200);
    check1("b_br_req_valid", s_req_valid, 1'b0);
    step(0, 0, 1, 0, 32'h0);
    check32("b_post_req_addr", s_req_addr, 32'h200);
    repeat (5) step(0, 0, 1, 0, 32'h0);
    check32("b_drained", 32'(exp_q.size()), 32'h0);

    // backpressure: stall from the first cycle for 10 cycles
    bus_lat = 1;
    do_reset();
    hs_count = 0;
    mon_en = 1'b1;
    exp_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, 0, 32'h0);
      check1($sformatf("c_stall%0d_valid", i), valid_out, 1'b0);
    end
    check32("c_handshakes", 32'(hs_count), 32'd4);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0, 32'h0);
      check1($sformatf("c_rel%0d_valid", i), valid_out, 1'b1);
    end
    check32("c_drained", 32'(exp_q.size()), 32'h0);

    // asynchronous reset in the middle of a burst
    bus_lat = 1;
    do_reset();
    mon_en = 1'b1;
    exp_q = '{32'h00, 32'h04, 32'h08, 32'h0C};
    repeat (5) step(0, 0, 1, 0, 32'h0);
    check1("d_pre_valid", valid_out, 1'b1);
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check1("d_async_req_valid", imem_req_valid, 1'b0);
    check1("d_async_valid_out", valid_out, 1'b0);
    check32("d_async_instr", instr_out, NOP);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    step(0, 0, 1, 0, 32'h0);
    check1("d_first_req_valid", s_req_valid, 1'b1);
    check32("d_first_req_addr", s_req_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
